// File: rtl/fides_pkg.sv
// Shared constants, types and helpers for the Fides-192 TI
// MixColumns datapath (6-bit elements, 3 shares, 4x8 state).
package fides_pkg;

  localparam int W    = 6;
  localparam int NSHR = 3;
  localparam int NCOL = 8;
  localparam int ROWS = 4;
  localparam int RW   = 2;
  localparam int CW   = 3;
  localparam int COLW = NSHR * ROWS * W;
  localparam int YW   = NSHR * W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CALC
  } state_t;

  typedef logic [RW-1:0] row_t;
  typedef logic [CW-1:0] col_t;

  // Element of share s, row r from a packed column.
  function automatic logic [W-1:0] pick(
    input logic [COLW-1:0] c,
    input int              s,
    input row_t            r
  );
    return c[(s*ROWS + int'(r))*W +: W];
  endfunction

endpackage

// File: rtl/mcol_elem.sv
// One-share 3-operand XOR for a single MixColumns element.
// Ports: a1/a2/a3 (W bits, same share) in, y = a1^a2^a3 out.
module mcol_elem
  import fides_pkg::*;
(
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic [W-1:0] a3,
  output logic [W-1:0] y
);

  assign y = a1 ^ a2 ^ a3;

endmodule

// File: rtl/mcol_sched.sv
// Serial TI MixColumns scheduler: one column per handshake in,
// one element (all shares) per cycle out, rows 0..3 in order.
// Ports: clk, rst (sync, active high), start, abort,
//   in_valid/in_ready/in_col, out_valid/out_ready/out_y,
//   out_row, out_col, busy, done, rnd (MCOL_REMASK_EN only).
// Build option: define MCOL_REMASK_EN to add fresh-mask port rnd.
module mcol_sched
  import fides_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [COLW-1:0] in_col,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [YW-1:0]   out_y,
  output logic [RW-1:0]   out_row,
  output logic [CW-1:0]   out_col,
  output logic            busy,
  output logic            done
`ifdef MCOL_REMASK_EN
  ,
  input  logic [2*W-1:0]  rnd
`endif
);

  state_t          state;
  state_t          state_n;
  row_t            row;
  row_t            row_n;
  row_t            nrow;
  col_t            col;
  col_t            col_n;
  logic [COLW-1:0] col_q;
  logic [COLW-1:0] src;
  logic [YW-1:0]   y_mix;
  logic [YW-1:0]   mask;
  logic [YW-1:0]   y_n;
  logic            done_n;
  logic            load_y;
  logic            take;

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    nrow    = row;
    done_n  = 1'b0;
    load_y  = 1'b0;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = WAIT;
          col_n   = '0;
          row_n   = '0;
        end
      end
      WAIT: begin
        if (in_valid) begin
          take    = 1'b1;
          load_y  = 1'b1;
          nrow    = '0;
          row_n   = '0;
          state_n = CALC;
        end
      end
      CALC: begin
        if (out_ready) begin
          if (&row) begin
            row_n = '0;
            if (col == CW'(NCOL-1)) begin
              done_n  = 1'b1;
              col_n   = '0;
              state_n = IDLE;
            end else begin
              col_n   = col + 1'b1;
              state_n = WAIT;
            end
          end else begin
            row_n  = row + 1'b1;
            nrow   = row + 1'b1;
            load_y = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // abort beats every other event; out_y keeps its value
    if (abort) begin
      state_n = IDLE;
      row_n   = '0;
      col_n   = '0;
      done_n  = 1'b0;
      load_y  = 1'b0;
      take    = 1'b0;
    end
  end

  // Row 0 is computed straight from in_col on the accept edge,
  // so the first element is valid the cycle after the handshake.
  assign src = take ? in_col : col_q;

  for (genvar s = 0; s < NSHR; s++) begin : g_sh
    mcol_elem u_elem (
      .a1 (pick(src, s, nrow + 2'd1)),
      .a2 (pick(src, s, nrow + 2'd2)),
      .a3 (pick(src, s, nrow + 2'd3)),
      .y  (y_mix[s*W +: W])
    );
  end

`ifdef MCOL_REMASK_EN
  // share masks r0, r1, r0^r1 cancel in the unshared value
  assign mask = {rnd[W-1:0] ^ rnd[2*W-1:W],
                 rnd[2*W-1:W],
                 rnd[W-1:0]};
`else
  assign mask = '0;
`endif

  assign y_n = y_mix ^ mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      col_q <= '0;
      out_y <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      done  <= done_n;
      if (take)   col_q <= in_col;
      if (load_y) out_y <= y_n;
    end
  end

  assign in_ready  = (state == WAIT);
  assign out_valid = (state == CALC);
  assign busy      = (state != IDLE);
  assign out_row   = row;
  assign out_col   = col;

endmodule

// File: tb/tb_mcol_sched.sv
// Self-checking bench for mcol_sched: vector table, hand
// sequences, and randomized rounds against a row-XOR model.
module tb_mcol_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_col;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_y;
  logic [1:0]  out_row;
  logic [2:0]  out_col;
  logic        busy;
  logic        done;
  logic [11:0] rnd_drv;

`ifdef MCOL_REMASK_EN
  localparam bit REMASK = 1'b1;
`else
  localparam bit REMASK = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcol_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
`ifdef MCOL_REMASK_EN
    ,
    .rnd       (rnd_drv)
`endif
  );

  typedef logic [2:0][3:0][5:0] col_in_t;
  typedef logic [3:0][2:0][5:0] col_out_t;

  typedef struct packed {
    col_in_t  x;
    col_out_t y;
  } vec_t;

  vec_t tbl [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] xor3(input logic [17:0] v);
    return v[5:0] ^ v[11:6] ^ v[17:12];
  endfunction

  function automatic logic [17:0] masked(input logic [17:0] b,
                                         input logic [11:0] rv);
    logic [17:0] m;
    m = REMASK ? {rv[5:0] ^ rv[11:6], rv[11:6], rv[5:0]} : 18'h0;
    return b ^ m;
  endfunction

  // Random sharing of a random column; each output row of a share
  // is the XOR of that share's other three rows.
  task automatic gen(output col_in_t x, output col_out_t yb);
    logic [5:0] u;
    for (int r = 0; r < 4; r++) begin
      u       = 6'($urandom);
      x[0][r] = 6'($urandom);
      x[1][r] = 6'($urandom);
      x[2][r] = u ^ x[0][r] ^ x[1][r];
    end
    for (int r = 0; r < 4; r++)
      for (int s = 0; s < 3; s++) begin
        yb[r][s] = 6'h0;
        for (int j = 0; j < 4; j++)
          if (j != r) yb[r][s] ^= x[s][j];
      end
  endtask

  // Starts in WAIT. pre: idle cycles before in_valid; st_row/st_n:
  // back-pressure; ab_row: abort at that row; rr: random rnd.
  task automatic do_col(input col_in_t x, input col_out_t yb,
                        input int ci, input int pre,
                        input int st_row, input int st_n,
                        input int ab_row, input bit last,
                        input bit rr);
    logic [11:0] rl;
    logic [17:0] ey;
    for (int k = 0; k < pre; k++) begin
      chk("wait_in_ready", 32'(in_ready), 1);
      chk("wait_out_valid", 32'(out_valid), 0);
      tick();
    end
    chk("in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_col   = x;
    if (rr) rnd_drv = 12'($urandom);
    rl = rnd_drv;
    tick();
    in_valid = 1'b0;
    in_col   = {8'($urandom), $urandom, $urandom};
    for (int r = 0; r < 4; r++) begin
      ey = masked(yb[r], rl);
      chk("out_valid", 32'(out_valid), 1);
      chk("out_row", 32'(out_row), 32'(r));
      chk("out_col", 32'(out_col), 32'(ci));
      chk("out_y", 32'(out_y), 32'(ey));
      chk("unshared", 32'(xor3(out_y)), 32'(xor3(yb[r])));
      chk("in_ready_calc", 32'(in_ready), 0);
      chk("done_mid", 32'(done), 0);
      if (r == ab_row) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_valid", 32'(out_valid), 0);
        chk("ab_in_ready", 32'(in_ready), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_row", 32'(out_row), 0);
        chk("ab_col", 32'(out_col), 0);
        chk("ab_y_hold", 32'(out_y), 32'(ey));
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("ab_no_done", 32'(done), 0);
          chk("ab_idle", 32'(busy), 0);
        end
        return;
      end
      if (r == st_row) begin
        out_ready = 1'b0;
        for (int k = 0; k < st_n; k++) begin
          if (rr) rnd_drv = 12'($urandom);
          start = 1'b1;
          tick();
          chk("hold_y", 32'(out_y), 32'(ey));
          chk("hold_row", 32'(out_row), 32'(r));
          chk("hold_col", 32'(out_col), 32'(ci));
          chk("hold_valid", 32'(out_valid), 1);
          chk("hold_in_ready", 32'(in_ready), 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
      end
      if (rr) rnd_drv = 12'($urandom);
      rl = rnd_drv;
      tick();
    end
    if (last) begin
      chk("done_end", 32'(done), 1);
      chk("busy_end", 32'(busy), 0);
      chk("in_ready_end", 32'(in_ready), 0);
    end else begin
      chk("done_col", 32'(done), 0);
      chk("in_ready_next", 32'(in_ready), 1);
      chk("valid_gap", 32'(out_valid), 0);
    end
  endtask

  col_in_t  rx;
  col_out_t ry;
  int       t0;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_col    = '0;
    out_ready = 1'b1;
    rnd_drv   = {6'h2A, 6'h15};

    tbl[0].x    = '0;
    tbl[0].x[0] = {6'h08, 6'h04, 6'h02, 6'h01};
    tbl[0].y    = '0;
    tbl[0].y[0][0] = 6'h0E;
    tbl[0].y[1][0] = 6'h0D;
    tbl[0].y[2][0] = 6'h0B;
    tbl[0].y[3][0] = 6'h07;
    tbl[1].x    = '0;
    tbl[1].x[1] = {6'h00, 6'h00, 6'h00, 6'h3F};
    tbl[1].y    = '0;
    tbl[1].y[1][1] = 6'h3F;
    tbl[1].y[2][1] = 6'h3F;
    tbl[1].y[3][1] = 6'h3F;
    tbl[2].x    = '0;
    tbl[2].x[0] = {6'h04, 6'h33, 6'h22, 6'h11};
    tbl[2].x[2] = {6'h01, 6'h01, 6'h01, 6'h01};
    tbl[2].y    = '0;
    tbl[2].y[0][0] = 6'h15;
    tbl[2].y[1][0] = 6'h26;
    tbl[2].y[2][0] = 6'h37;
    for (int r = 0; r < 4; r++) tbl[2].y[r][2] = 6'h01;

    // reset
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_row", 32'(out_row), 0);
    chk("rst_out_col", 32'(out_col), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_in_ready", 32'(in_ready), 1);

    // vector table, fixed rnd
    for (int i = 0; i < 3; i++)
      do_col(tbl[i].x, tbl[i].y, i, 0, 4, 0, -1, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("tbl_abort_busy", 32'(busy), 0);

    // abort and start together in IDLE
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_start_busy", 32'(busy), 0);
    chk("ab_start_rdy", 32'(in_ready), 0);

    // full round at line rate: done exactly 40 cycles after start
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    for (int c = 0; c < 8; c++) begin
      gen(rx, ry);
      do_col(rx, ry, c, 0, 4, 0, -1, c == 7, 1'b1);
    end
    chk("round_latency", 32'(cyc - t0), 40);
    tick();
    chk("done_pulse_end", 32'(done), 0);
    chk("idle_col", 32'(out_col), 0);

    // random gaps and stalls; 5-cycle stall on row 2 of column 3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      gen(rx, ry);
      if (c == 3)
        do_col(rx, ry, c, 0, 2, 5, -1, 1'b0, 1'b1);
      else
        do_col(rx, ry, c, $urandom_range(0, 2),
               $urandom_range(0, 4), $urandom_range(1, 3),
               -1, c == 7, 1'b1);
    end
    tick();
    chk("done_once", 32'(done), 0);

    // abort in column 5 row 1, then restart from column 0
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      gen(rx, ry);
      do_col(rx, ry, c, 0, 4, 0, -1, 1'b0, 1'b1);
    end
    gen(rx, ry);
    do_col(rx, ry, 5, 0, 4, 0, 1, 1'b0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    gen(rx, ry);
    do_col(rx, ry, 0, 0, 4, 0, -1, 1'b0, 1'b1);

    // reset in the middle of a column
    in_valid = 1'b1;
    in_col   = rx;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_y", 32'(out_y), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_row", 32'(out_row), 0);
    chk("mid_rst_col", 32'(out_col), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
